// File: rtl/riscv_ex_pipeline_if.sv
// Handshake bundle between decode (ID/EX) and the MEM/WB side of the execute buffer.
// The slave modport is the stage itself. The master modport is whatever drives it.
interface riscv_ex_pipeline_if #(
    parameter int DATA_W = 32
);
    logic              id_ex_rdy;
    logic              id_ex_ack;
    logic [DATA_W-1:0] id_ex_data;
    logic              mem_wb_rdy;
    logic              mem_wb_ack;
    logic [DATA_W-1:0] mem_wb_data;

    modport slave (
        input  id_ex_rdy, id_ex_data, mem_wb_ack,
        output id_ex_ack, mem_wb_rdy, mem_wb_data
    );

    modport master (
        output id_ex_rdy, id_ex_data, mem_wb_ack,
        input  id_ex_ack, mem_wb_rdy, mem_wb_data
    );
endinterface

// File: rtl/riscv_ex_pipeline.sv
// Execute-stage elastic buffer: a DEPTH-entry circular FIFO that passes words in order.
// Both handshake outputs come only from registered state.
module riscv_ex_pipeline #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    riscv_ex_pipeline_if.slave       bus
);
    localparam int             PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] entry [DEPTH];
    logic [PTR_W-1:0]  wp, rp;
    logic [CNT_W-1:0]  count;
    logic              accept, pop;

    assign bus.id_ex_ack   = (count != FULL);
    assign bus.mem_wb_rdy  = (count != '0);
    assign bus.mem_wb_data = entry[rp];

    assign accept = bus.id_ex_rdy && bus.id_ex_ack;
    assign pop    = bus.mem_wb_rdy && bus.mem_wb_ack;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
        end else if (accept) begin
            entry[wp] <= bus.id_ex_data;
        end
    end

    // Pointers wrap explicitly so DEPTH does not have to be a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (accept) wp <= (wp == LAST) ? '0 : wp + 1'b1;
            if (pop)    rp <= (rp == LAST) ? '0 : rp + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (accept && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !accept) begin
            count <= count - 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        count <= FULL);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
        !(pop && !accept && count == '0));

endmodule

// File: tb/tb_riscv_ex_pipeline.sv
// Scoreboard bench for riscv_ex_pipeline: words are queued on accept and compared at the head.
module tb_riscv_ex_pipeline;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   pops;
    logic [DATA_W-1:0] q[$];

    riscv_ex_pipeline_if #(.DATA_W(DATA_W)) bus();

    riscv_ex_pipeline #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus. This checks the head against the scoreboard, records transfers, and advances to edge+1.
    task automatic drive_cycle(input logic r, input logic [DATA_W-1:0] d, input logic a);
        logic exp_rdy, exp_ack;
        bus.id_ex_rdy  = r;
        bus.id_ex_data = d;
        bus.mem_wb_ack = a;
        exp_rdy = (q.size() != 0);
        exp_ack = (q.size() != DEPTH);
        total++;
        if (bus.mem_wb_rdy !== exp_rdy) begin
            bad++;
            $display("FAIL sb_rdy: got %b want %b at %0t", bus.mem_wb_rdy, exp_rdy, $time);
        end
        total++;
        if (bus.id_ex_ack !== exp_ack) begin
            bad++;
            $display("FAIL sb_ack: got %b want %b at %0t", bus.id_ex_ack, exp_ack, $time);
        end
        if (q.size() != 0) begin
            total++;
            if (bus.mem_wb_data !== q[0]) begin
                bad++;
                $display("FAIL sb_data: got %h want %h at %0t", bus.mem_wb_data, q[0], $time);
            end
        end
        if (a && bus.mem_wb_rdy === 1'b1) begin
            if (q.size() != 0) void'(q.pop_front());
            pops++;
        end
        if (r && bus.id_ex_ack === 1'b1) q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.id_ex_rdy  = 1'b0;
        bus.id_ex_data = '0;
        bus.mem_wb_ack = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.id_ex_ack !== 1'b1) begin bad++; $display("FAIL reset_ack: got %b want 1", bus.id_ex_ack); end
        total++;
        if (bus.mem_wb_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", bus.mem_wb_rdy); end
        total++;
        if (bus.mem_wb_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.mem_wb_data); end
        q.delete();
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 32'hDEADBEEF, 1'b0);
        total++;
        if (bus.mem_wb_rdy !== 1'b1 || bus.mem_wb_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_head: got rdy=%b data=%h want rdy=1 data=deadbeef", bus.mem_wb_rdy, bus.mem_wb_data);
        end
        drive_cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (bus.mem_wb_rdy !== 1'b0) begin bad++; $display("FAIL single_empty: got rdy=%b want 0", bus.mem_wb_rdy); end
        drive_cycle(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_fill();
        drive_cycle(1'b1, 32'h11, 1'b0);
        drive_cycle(1'b1, 32'h22, 1'b0);
        total++;
        if (bus.id_ex_ack !== 1'b0) begin bad++; $display("FAIL fill_full: got ack=%b want 0", bus.id_ex_ack); end
        drive_cycle(1'b1, 32'h33, 1'b0);
        drive_cycle(1'b1, 32'h33, 1'b0);
        total++;
        if (bus.mem_wb_data !== 32'h11) begin bad++; $display("FAIL fill_head: got %h want 11", bus.mem_wb_data); end
        drive_cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (bus.mem_wb_data !== 32'h22) begin bad++; $display("FAIL fill_second: got %h want 22", bus.mem_wb_data); end
        drive_cycle(1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (bus.mem_wb_rdy !== 1'b0) begin bad++; $display("FAIL fill_drop33: got rdy=%b want 0", bus.mem_wb_rdy); end
    endtask

    task automatic test_stream();
        pops = 0;
        for (int i = 1; i <= 10; i++) begin
            drive_cycle(1'b1, DATA_W'(i), 1'b1);
            total++;
            if (dut.count !== 5'd1) begin bad++; $display("FAIL stream_count: got %0d want 1 at word %0d", dut.count, i); end
        end
        drive_cycle(1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b0);
        total++;
        if (pops != 10) begin bad++; $display("FAIL stream_pops: got %0d want 10", pops); end
    endtask

    task automatic test_random_stalls();
        int sent, gap, cyc;
        logic r, a, accepted;
        logic [DATA_W-1:0] w;
        sent = 0; gap = 0; cyc = 0; pops = 0;
        w = $urandom;
        while ((sent < 100 || q.size() != 0) && cyc < 5000) begin
            r = (sent < 100) && (gap == 0);
            a = 1'($urandom_range(0, 1));
            accepted = r && (bus.id_ex_ack === 1'b1);
            drive_cycle(r, w, a);
            if (accepted) begin
                sent++;
                w = $urandom;
                gap = $urandom_range(1, 5);
            end else if (gap > 0) begin
                gap--;
            end
            cyc++;
        end
        total++;
        if (cyc >= 5000) begin bad++; $display("FAIL random_timeout: got %0d cycles want <5000", cyc); end
        total++;
        if (pops != 100) begin bad++; $display("FAIL random_pops: got %0d want 100", pops); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 32'hA5A5_0001, 1'b0);
        drive_cycle(1'b1, 32'hA5A5_0002, 1'b0);
        rstn = 1'b0;
        #1;
        total++;
        if (bus.mem_wb_rdy !== 1'b0) begin bad++; $display("FAIL midrst_rdy: got %b want 0", bus.mem_wb_rdy); end
        total++;
        if (bus.id_ex_ack !== 1'b1) begin bad++; $display("FAIL midrst_ack: got %b want 1", bus.id_ex_ack); end
        q.delete();
        bus.id_ex_rdy = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'h0, 1'b1);
        pops = 0;
        drive_cycle(1'b1, 32'h0000_0055, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (pops != 1) begin bad++; $display("FAIL midrst_pops: got %0d want 1", pops); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pops  = 0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random_stalls();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
